// File: rtl/h264dcquantise.sv
// rtl/h264dcquantise.sv - H.264 chroma DC quantiser with FWFT output FIFO
module h264dcquantise #(
  parameter int DEPTH = 8
) (
  input  logic        i_clk2,
  input  logic        i_reset_n,
  input  logic [5:0]  i_qp,
  input  logic        i_intra,
  output logic        o_readyi,
  input  logic        i_validi,
  input  logic [15:0] i_coefin,
  output logic        o_valido,
  output logic [11:0] o_level,
  output logic        o_last,
  output logic [2:0]  o_nzcount,
  input  logic        i_readyo
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + 4);

  // Splits a clamped QP into {qp/6, qp%6} without a divider.
  function automatic logic [6:0] qsplit(input logic [5:0] q);
    logic [3:0] d;
    logic [5:0] r;
    if      (q < 6'd6)  d = 4'd0;
    else if (q < 6'd12) d = 4'd1;
    else if (q < 6'd18) d = 4'd2;
    else if (q < 6'd24) d = 4'd3;
    else if (q < 6'd30) d = 4'd4;
    else if (q < 6'd36) d = 4'd5;
    else if (q < 6'd42) d = 4'd6;
    else if (q < 6'd48) d = 4'd7;
    else                d = 4'd8;
    r = q - ({2'b00, d} * 6'd6);
    return {d, r[2:0]};
  endfunction

  // Position-(0,0) multiplication factor by qp%6.
  function automatic logic [13:0] mf_of(input logic [2:0] m);
    case (m)
      3'd0:    mf_of = 14'd13107;
      3'd1:    mf_of = 14'd11916;
      3'd2:    mf_of = 14'd10082;
      3'd3:    mf_of = 14'd9362;
      3'd4:    mf_of = 14'd8192;
      default: mf_of = 14'd7282;
    endcase
  endfunction

  // block-level state
  logic [1:0]  r_cidx;
  logic [3:0]  r_qdiv;
  logic [2:0]  r_qmod;
  logic        r_intra;
  logic [2:0]  r_nzacc;

  // S0
  logic        r_s0_v;
  logic [15:0] r_s0_abs;
  logic        r_s0_neg;
  logic [1:0]  r_s0_idx;
  logic [3:0]  r_s0_qdiv;
  logic [13:0] r_s0_mf;
  logic        r_s0_intra;

  // S1
  logic        r_s1_v;
  logic [31:0] r_s1_p;
  logic        r_s1_neg;
  logic [1:0]  r_s1_idx;
  logic [3:0]  r_s1_qdiv;
  logic        r_s1_intra;

  // S2
  logic        r_s2_v;
  logic [11:0] r_s2_level;
  logic        r_s2_last;
  logic [2:0]  r_s2_nz;

  // FIFO
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [5:0]  w_qpc;
  logic [6:0]  w_qsplit;
  logic [3:0]  w_qdiv_sel;
  logic [2:0]  w_qmod_sel;
  logic        w_intra_sel;
  logic [15:0] w_abs;
  logic [31:0] w_off;
  logic [31:0] w_sum;
  logic [31:0] w_m;
  logic [11:0] w_mag;
  logic [11:0] w_level;
  logic        w_nz;
  logic [2:0]  w_acc;
  logic        w_push;
  logic        w_pop;
  logic [15:0] w_head;
  logic [OW-1:0] w_occ;

  // Word 0 of a block takes QP/INTRA live; later words reuse the latched copy,
  // so mid-block parameter changes never split a block.
  always_comb begin
    w_qpc       = (i_qp > 6'd51) ? 6'd51 : i_qp;
    w_qsplit    = qsplit(w_qpc);
    w_qdiv_sel  = (r_cidx == 2'd0) ? w_qsplit[6:3] : r_qdiv;
    w_qmod_sel  = (r_cidx == 2'd0) ? w_qsplit[2:0] : r_qmod;
    w_intra_sel = (r_cidx == 2'd0) ? i_intra : r_intra;
    w_abs       = i_coefin[15] ? (~i_coefin + 16'd1) : i_coefin;
  end

  // Rounding, shift, saturation and nonzero count for the word leaving S1.
  always_comb begin
    w_off = (r_s1_intra ? 32'd21845 : 32'd10922) << r_s1_qdiv;
    w_sum = r_s1_p + w_off;
    w_m   = w_sum >> (5'd16 + {1'b0, r_s1_qdiv});
    if (r_s1_neg) w_mag = (w_m >= 32'd2048) ? 12'd2048 : w_m[11:0];
    else          w_mag = (w_m >= 32'd2047) ? 12'd2047 : w_m[11:0];
    w_level = r_s1_neg ? (~w_mag + 12'd1) : w_mag;
    w_nz    = (w_m != 32'd0);
    w_acc   = (r_s1_idx == 2'd0) ? {2'b00, w_nz} : (r_nzacc + {2'b00, w_nz});
  end

  // Block index, parameter latch and the three pipeline stages.
  always_ff @(posedge i_clk2 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cidx     <= 2'd0;
      r_qdiv     <= 4'd0;
      r_qmod     <= 3'd0;
      r_intra    <= 1'b0;
      r_nzacc    <= 3'd0;
      r_s0_v     <= 1'b0;
      r_s0_abs   <= 16'd0;
      r_s0_neg   <= 1'b0;
      r_s0_idx   <= 2'd0;
      r_s0_qdiv  <= 4'd0;
      r_s0_mf    <= 14'd0;
      r_s0_intra <= 1'b0;
      r_s1_v     <= 1'b0;
      r_s1_p     <= 32'd0;
      r_s1_neg   <= 1'b0;
      r_s1_idx   <= 2'd0;
      r_s1_qdiv  <= 4'd0;
      r_s1_intra <= 1'b0;
      r_s2_v     <= 1'b0;
      r_s2_level <= 12'd0;
      r_s2_last  <= 1'b0;
      r_s2_nz    <= 3'd0;
    end else begin
      r_s0_v <= i_validi;
      if (i_validi) begin
        r_cidx <= r_cidx + 2'd1;
        if (r_cidx == 2'd0) begin
          r_qdiv  <= w_qsplit[6:3];
          r_qmod  <= w_qsplit[2:0];
          r_intra <= i_intra;
        end
        r_s0_abs   <= w_abs;
        r_s0_neg   <= i_coefin[15];
        r_s0_idx   <= r_cidx;
        r_s0_qdiv  <= w_qdiv_sel;
        r_s0_mf    <= mf_of(w_qmod_sel);
        r_s0_intra <= w_intra_sel;
      end

      r_s1_v <= r_s0_v;
      if (r_s0_v) begin
        r_s1_p     <= 32'(r_s0_abs) * 32'(r_s0_mf);
        r_s1_neg   <= r_s0_neg;
        r_s1_idx   <= r_s0_idx;
        r_s1_qdiv  <= r_s0_qdiv;
        r_s1_intra <= r_s0_intra;
      end

      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_nzacc    <= w_acc;
        r_s2_level <= w_level;
        r_s2_last  <= (r_s1_idx == 2'd3);
        r_s2_nz    <= (r_s1_idx == 2'd3) ? w_acc : 3'd0;
      end
    end
  end

  assign w_push = r_s2_v;
  assign w_pop  = o_valido & i_readyo;

  // FIFO storage; contents are masked at the outputs when empty, so no reset.
  always_ff @(posedge i_clk2) begin
    if (w_push) r_mem[r_wptr] <= {r_s2_level, r_s2_last, r_s2_nz};
  end

  // FIFO pointers and count; push is never refused because READYI keeps room.
  always_ff @(posedge i_clk2 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
      if (w_pop)  r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry falls through; outputs read zero whenever the FIFO is empty.
  always_comb begin
    w_head    = r_mem[r_rptr];
    o_valido  = (r_count != '0);
    o_level   = o_valido ? w_head[15:4] : 12'd0;
    o_last    = o_valido ? w_head[3]    : 1'b0;
    o_nzcount = o_valido ? w_head[2:0]  : 3'd0;
    w_occ     = OW'(r_count) + OW'(r_s0_v) + OW'(r_s1_v) + OW'(r_s2_v);
    o_readyi  = (w_occ <= OW'(2));
  end

endmodule

// File: tb/tb_h264dcquantise.sv
// tb/tb_h264dcquantise.sv - scoreboard bench for the chroma DC quantiser
module tb_h264dcquantise;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  qp;
  logic        intra;
  logic        readyi;
  logic        validi;
  logic [15:0] coefin;
  logic        valido;
  logic [11:0] level;
  logic        last;
  logic [2:0]  nz;
  logic        readyo;

  typedef struct packed {
    logic [11:0] lv;
    logic        last;
    logic [2:0]  nz;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pops = 0;
  int   occ_max = 0;
  int   lat_cyc = -1;
  bit   arm = 1'b0;
  bit   held_v = 1'b0;
  logic [15:0] held;

  h264dcquantise #(.DEPTH(8)) dut (
    .i_clk2    (clk),
    .i_reset_n (rst_n),
    .i_qp      (qp),
    .i_intra   (intra),
    .o_readyi  (readyi),
    .i_validi  (validi),
    .i_coefin  (coefin),
    .o_valido  (valido),
    .o_level   (level),
    .o_last    (last),
    .o_nzcount (nz),
    .i_readyo  (readyo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pops the scoreboard on every transfer, checks hold and empty behaviour
  always @(negedge clk) begin
    exp_t e;
    if (int'(dut.w_occ) > occ_max) occ_max = int'(dut.w_occ);
    if (rst_n) begin
      if (arm && valido) begin
        lat_cyc = cyc;
        arm = 1'b0;
      end
      if (valido && readyo) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output level=%0d last=%0b nz=%0d", $signed(level), last, nz);
        end else begin
          e = q.pop_front();
          if ({level, last, nz} != e) begin
            errors++;
            $display("FAIL level_out got %0d/%0b/%0d need %0d/%0b/%0d",
                     $signed(level), last, nz, $signed(e.lv), e.last, e.nz);
          end
        end
        pops++;
      end
      if (!valido) begin
        checks++;
        if ({level, last, nz} != 16'd0) begin
          errors++;
          $display("FAIL empty_hold got %h need 0", {level, last, nz});
        end
      end
      if (valido && !readyo) begin
        if (held_v) begin
          checks++;
          if ({level, last, nz} != held) begin
            errors++;
            $display("FAIL head_stable got %h need %h", {level, last, nz}, held);
          end
        end
        held   = {level, last, nz};
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d need %0d", name, got, want);
    end
  endtask

  task automatic send_block(input logic [5:0] qa, input logic [5:0] qb, input logic in,
                            input int c0, input int c1, input int c2, input int c3,
                            input int l0, input int l1, input int l2, input int l3,
                            input int nzc);
    int   c[4];
    int   l[4];
    exp_t e;
    c = '{c0, c1, c2, c3};
    l = '{l0, l1, l2, l3};
    for (int w = 0; w < 4; w++) begin
      validi = 1'b1;
      coefin = 16'(c[w]);
      qp     = (w == 0) ? qa : qb;
      intra  = in;
      e.lv   = 12'(l[w]);
      e.last = (w == 3);
      e.nz   = (w == 3) ? 3'(nzc) : 3'd0;
      q.push_back(e);
      step();
    end
    validi = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((q.size() != 0 || valido) && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d left need 0", q.size());
    end
  endtask

  // main stimulus
  initial begin
    int t_in;
    int pops0;
    int blocks;
    rst_n  = 1'b0;
    validi = 1'b0;
    coefin = 16'd0;
    qp     = 6'd0;
    intra  = 1'b0;
    readyo = 1'b1;
    repeat (3) step();
    chk("rst_valido", valido, 0);
    chk("rst_level", level, 0);
    chk("rst_last", last, 0);
    chk("rst_nzcount", nz, 0);
    chk("rst_readyi", readyi, 1);
    @(negedge clk) rst_n = 1'b1;
    step();

    // QP=28 intra, latency
    t_in = cyc + 1;
    arm  = 1'b1;
    send_block(6'd28, 6'd28, 1'b1, 100, 0, -100, 0, 1, 0, -1, 0, 2);
    drain(20);
    chk("latency", lat_cyc, t_in + 3);

    // QP=0 intra with saturation
    send_block(6'd0, 6'd0, 1'b1, -1000, 1000, 32767, -32768, -200, 200, 2047, -2048, 4);
    drain(20);

    // rounding offset inter vs intra
    send_block(6'd0, 6'd0, 1'b0, 5, 2, 3, 0, 1, 0, 0, 0, 1);
    send_block(6'd0, 6'd0, 1'b1, 5, 2, -5, 0, 1, 0, -1, 0, 2);
    drain(20);

    // QP change mid-block, QP clamp
    send_block(6'd12, 6'd40, 1'b1, 1000, 1000, 1000, 1000, 50, 50, 50, 50, 4);
    send_block(6'd40, 6'd40, 1'b1, 1000, -1000, 0, 30000, 2, -2, 0, 58, 3);
    send_block(6'd60, 6'd60, 1'b1, 32767, -32768, 1000, 2000, 18, -18, 0, 1, 3);
    drain(30);

    // back-pressure: 8 blocks under READYI control with READYO held low
    readyo  = 1'b0;
    occ_max = 0;
    pops0   = pops;
    blocks  = 0;
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          int to;
          int n0;
          to = 0;
          while (!readyi && to < 500) begin
            step();
            to++;
          end
          if (to >= 500) begin
            checks++;
            errors++;
            $display("FAIL readyi_timeout got 0 need 1");
          end
          n0 = b * 4;
          send_block(6'd0, 6'd0, 1'b1,
                     5 * (n0 + 1), -5 * (n0 + 2), 5 * (n0 + 3), -5 * (n0 + 4),
                     n0 + 1, -(n0 + 2), n0 + 3, -(n0 + 4), 4);
          blocks++;
        end
      end
      begin
        repeat (40) step();
        chk("readyi_low", readyi, 0);
        chk("blocks_held", blocks, 1);
        chk("valid_held", valido, 1);
        readyo = 1'b1;
      end
    join
    drain(300);
    chk("drain_count", pops - pops0, 32);
    chk("occ_range", (occ_max >= 4 && occ_max <= 8) ? 1 : 0, 1);

    // reset mid-block with 3 entries buffered
    readyo = 1'b0;
    send_block(6'd0, 6'd0, 1'b1, 5, 10, 15, 20, 1, 2, 3, 4, 4);
    repeat (5) step();
    readyo = 1'b1;
    step();
    readyo = 1'b0;
    validi = 1'b1;
    coefin = 16'd5;
    step();
    coefin = 16'd10;
    step();
    validi = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valido", valido, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_last", last, 0);
    chk("mid_rst_nzcount", nz, 0);
    chk("mid_rst_readyi", readyi, 1);
    q.delete();
    step();
    step();
    @(negedge clk) rst_n = 1'b1;
    readyo = 1'b1;
    step();
    send_block(6'd0, 6'd0, 1'b1, 0, 5, -10, 0, 0, 1, -2, 0, 2);
    drain(20);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
